jtag_mem_master: RTL and testbench

JTAG-driven memory bus master sitting behind the BSCAN user-register chain, next to the address/control register. Takes the address register's ADDR/WR/INC fields, owns a data DR shift chain, and sequences single-beat reads and writes onto the SoC memory bus with optional auto-increment. Gives the debug host block-level memory access without an on-chip CPU. Everything runs in the TCK domain.

---
 rtl/jtag_mem_pkg.sv | 21 ++
 rtl/jtag_dr_shift.sv | 27 ++
 rtl/jtag_mem_master.sv | 155 +++++++++++++++
 tb/tb_jtag_mem_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_mem_pkg.sv
// Shared types and constants for the JTAG memory bus master: FSM states,
// status-bit positions in the data DR, and the auto-increment step.
package jtag_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // The status bits sit directly above the DW-bit read buffer in the captured DR.
    function automatic int err_bit(input int dw);
        return dw;
    endfunction

    function automatic int busy_bit(input int dw);
        return dw + 1;
    endfunction

    // One beat is DW/8 bytes, so auto-increment steps by that amount.
    function automatic int addr_inc(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// BSCAN data-register capture/shift chain; capture wins over shift when both are set.
module jtag_dr_shift #(
    parameter int W  = 66,
    parameter int PW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic          shift_en,
    input  logic          tdi,
    input  logic [W-1:0]  cap_data,
    output logic [PW-1:0] par,
    output logic          tdo
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst)           sr <= '0;
        else if (cap_en)   sr <= cap_data;
        else if (shift_en) sr <= {tdi, sr[W-1:1]};
    end

    assign tdo = sr[0];
    assign par = sr[PW-1:0];

endmodule

// File: rtl/jtag_mem_master.sv
// JTAG-driven single-beat memory bus master in the TCK domain.
// Optional bus timeout enabled with `define JTAG_MEM_TIMEOUT_EN.
module jtag_mem_master import jtag_mem_pkg::*; #(
    parameter int DW   = 64,
    parameter int AW   = 32,
    parameter int TO_W = 10
) (
    input  logic            TCK,
    input  logic            RESET,
    input  logic            SEL,
    input  logic            CAPTURE,
    input  logic            SHIFT,
    input  logic            UPDATE,
    input  logic            TDI,
    output logic            TDO,
    input  logic [AW-1:0]   ADDR_IN,
    input  logic            WR_IN,
    input  logic            INC_IN,
    input  logic            ADDR_LOAD,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic [AW-1:0]   MEM_ADDR,
    output logic [DW-1:0]   MEM_WDATA,
    output logic [DW/8-1:0] MEM_BE,
    input  logic            MEM_GNT,
    input  logic            MEM_RVALID,
    input  logic            MEM_ERR,
    input  logic [DW-1:0]   MEM_RDATA
);

    localparam int            ERR_B  = err_bit(DW);
    localparam int            BUSY_B = busy_bit(DW);
    localparam logic [AW-1:0] INC    = AW'(addr_inc(DW));

    state_t        state;
    logic [AW-1:0] cur_addr, nxt_addr;
    logic          wrm, incm, err, pend, discard;
    logic [DW-1:0] rbuf, wbuf, sr_par;
    logic [DW+1:0] cap;
    logic          busy, upd, cmpl, tmo, fin, keep;

    jtag_dr_shift #(.W(DW + 2), .PW(DW)) u_dr (
        .clk      (TCK),
        .rst      (RESET),
        .cap_en   (SEL & CAPTURE),
        .shift_en (SEL & SHIFT),
        .tdi      (TDI),
        .cap_data (cap),
        .par      (sr_par),
        .tdo      (TDO)
    );

    always_comb begin
        cap         = '0;
        cap[DW-1:0] = rbuf;
        cap[ERR_B]  = err;
        cap[BUSY_B] = busy;
    end

    assign busy     = (state != IDLE);
    assign upd      = SEL & UPDATE & ~ADDR_LOAD;
    assign cmpl     = ((state == REQ) & MEM_GNT & MEM_RVALID) | ((state == WAIT) & MEM_RVALID);
    assign fin      = cmpl | tmo;
    // A transaction superseded by ADDR_LOAD still runs on the bus but leaves no trace.
    assign keep     = ~discard & ~ADDR_LOAD;
    assign nxt_addr = incm ? cur_addr + INC : cur_addr;
    assign MEM_WDATA = wbuf;
    assign MEM_BE    = '1;

`ifdef JTAG_MEM_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign tmo = (((state == REQ) & ~MEM_GNT) | ((state == WAIT) & ~MEM_RVALID)) & (to_cnt == '1);

    always_ff @(posedge TCK) begin
        if (RESET || !busy || fin || (state == REQ && MEM_GNT)) to_cnt <= '0;
        else                                                   to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge TCK) begin
        if (RESET) begin
            state    <= IDLE;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            cur_addr <= '0;
            wrm      <= 1'b0;
            incm     <= 1'b0;
            err      <= 1'b0;
            pend     <= 1'b0;
            discard  <= 1'b0;
            rbuf     <= '0;
            wbuf     <= '0;
        end else begin
            if (state == REQ && MEM_GNT && !MEM_RVALID) state <= WAIT;

            if (fin) begin
                state   <= IDLE;
                MEM_REQ <= 1'b0;
                discard <= 1'b0;
                if (keep) begin
                    if (tmo || MEM_ERR) err      <= 1'b1;
                    else if (!MEM_WE)   rbuf     <= MEM_RDATA;
                    else if (incm)      cur_addr <= cur_addr + INC;
                end
                // Prefetch queued by an ADDR_LOAD that arrived mid-transaction.
                if (pend) begin
                    state    <= REQ;
                    MEM_REQ  <= 1'b1;
                    MEM_WE   <= 1'b0;
                    MEM_ADDR <= cur_addr;
                    pend     <= 1'b0;
                end
            end

            if (upd) begin
                if (busy) begin
                    err <= 1'b1;
                end else begin
                    state   <= REQ;
                    MEM_REQ <= 1'b1;
                    MEM_WE  <= wrm;
                    if (wrm) begin
                        wbuf     <= sr_par;
                        MEM_ADDR <= cur_addr;
                    end else begin
                        MEM_ADDR <= nxt_addr;
                        cur_addr <= nxt_addr;
                    end
                end
            end

            if (ADDR_LOAD) begin
                cur_addr <= ADDR_IN;
                wrm      <= WR_IN;
                incm     <= INC_IN;
                err      <= 1'b0;
                if (busy && !fin) begin
                    discard <= 1'b1;
                    pend    <= ~WR_IN;
                end else begin
                    pend    <= 1'b0;
                    state   <= WR_IN ? IDLE : REQ;
                    MEM_REQ <= ~WR_IN;
                    MEM_WE  <= 1'b0;
                    if (!WR_IN) MEM_ADDR <= ADDR_IN;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_mem_master.sv
// Self-checking bench for jtag_mem_master: bus responder with memory plus a
// transaction-level reference model of address, status and read buffer.
module tb_jtag_mem_master;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int TO_W = 10;

    logic            TCK = 1'b0;
    logic            RESET, SEL, CAPTURE, SHIFT, UPDATE, TDI, TDO;
    logic [AW-1:0]   ADDR_IN;
    logic            WR_IN, INC_IN, ADDR_LOAD;
    logic            MEM_REQ, MEM_WE;
    logic [AW-1:0]   MEM_ADDR;
    logic [DW-1:0]   MEM_WDATA;
    logic [DW/8-1:0] MEM_BE;
    logic            MEM_GNT = 1'b0, MEM_RVALID = 1'b0, MEM_ERR = 1'b0;
    logic [DW-1:0]   MEM_RDATA = '0;

    jtag_mem_master #(.DW(DW), .AW(AW), .TO_W(TO_W)) dut (
        .TCK(TCK), .RESET(RESET), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
        .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .ADDR_IN(ADDR_IN), .WR_IN(WR_IN),
        .INC_IN(INC_IN), .ADDR_LOAD(ADDR_LOAD), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE), .MEM_GNT(MEM_GNT),
        .MEM_RVALID(MEM_RVALID), .MEM_ERR(MEM_ERR), .MEM_RDATA(MEM_RDATA)
    );

    always #5 TCK = ~TCK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    // Responder-side memory and independent model-side shadow.
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : seed_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
    endfunction

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    int   gnt_delay = 0;
    bit   err_inj = 1'b0;
    bit   resp_en = 1'b1;
    int   wcnt = 0;
    txn_t held;
    txn_t obs_q[$];

    // Grant after gnt_delay waiting cycles with RVALID in the same cycle.
    always @(negedge TCK) begin
        MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = '0;
        if (MEM_REQ && resp_en) begin
            if (wcnt == 0) held = {MEM_WE, MEM_ADDR, MEM_WDATA};
            else chk("req_stable", 128'({MEM_WE, MEM_ADDR, MEM_WDATA}), 128'(held));
            if (wcnt >= gnt_delay) begin
                MEM_GNT = 1'b1; MEM_RVALID = 1'b1; MEM_ERR = err_inj;
                if (!MEM_WE) MEM_RDATA = bus_rd(MEM_ADDR);
                else if (!err_inj) bus_mem[MEM_ADDR] = MEM_WDATA;
                obs_q.push_back(held);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Reference model state.
    logic [AW-1:0] m_addr;
    bit            m_wrm, m_inc, m_err;
    logic [DW-1:0] m_rbuf;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge TCK);
    endtask

    task automatic addr_load(input logic [AW-1:0] a, input bit wr, input bit inc);
        ADDR_IN = a; WR_IN = wr; INC_IN = inc; ADDR_LOAD = 1'b1;
        tick();
        ADDR_LOAD = 1'b0;
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic scan(input logic [DW+1:0] din, output logic [DW+1:0] dout);
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0; SHIFT = 1'b1;
        for (int i = 0; i < DW + 2; i++) begin
            dout[i] = TDO;
            TDI = din[i];
            tick();
        end
        SHIFT = 1'b0;
    endtask

    task automatic expect_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit apply);
        txn_t t;
        int   n = 0;
        while (obs_q.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        if (obs_q.size() == 0) begin
            chk("txn_timeout", 128'(0), 128'(1));
            return;
        end
        t = obs_q.pop_front();
        chk("txn_we", 128'(t.we), 128'(we));
        chk("txn_addr", 128'(t.addr), 128'(a));
        if (we) chk("txn_wdata", 128'(t.wdata), 128'(d));
        if (apply) begin
            if (err_inj) m_err = 1'b1;
            else if (we) begin
                ref_mem[a] = d;
                if (m_inc) m_addr = m_addr + AW'(DW / 8);
            end else m_rbuf = ref_rd(a);
        end
        tick();
    endtask

    task automatic op_load(input logic [AW-1:0] a, input bit wr, input bit inc);
        addr_load(a, wr, inc);
        m_addr = a; m_wrm = wr; m_inc = inc; m_err = 1'b0;
        if (!wr) expect_txn(1'b0, a, '0, 1'b1);
    endtask

    task automatic op_update(input logic [DW-1:0] d);
        logic [DW+1:0] dout;
        scan({2'b00, d}, dout);
        pulse_update();
        if (m_wrm) expect_txn(1'b1, m_addr, d, 1'b1);
        else begin
            if (m_inc) m_addr = m_addr + AW'(DW / 8);
            expect_txn(1'b0, m_addr, '0, 1'b1);
        end
    endtask

    task automatic check_status(input string tag);
        logic [DW+1:0] dout;
        scan('0, dout);
        chk(tag, 128'(dout), 128'({1'b0, m_err, m_rbuf}));
    endtask

    initial begin
        logic [DW+1:0] dout;
        logic [AW-1:0] a;
        int            n;

        RESET = 1'b1; SEL = 1'b1; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0; TDI = 1'b0;
        ADDR_IN = '0; WR_IN = 1'b0; INC_IN = 1'b0; ADDR_LOAD = 1'b0;
        m_addr = '0; m_wrm = 1'b0; m_inc = 1'b0; m_err = 1'b0; m_rbuf = '0;
        tick(3);
        chk("rst_req", 128'(MEM_REQ), 128'(0));
        chk("rst_we", 128'(MEM_WE), 128'(0));
        chk("rst_addr", 128'(MEM_ADDR), 128'(0));
        chk("rst_wdata", 128'(MEM_WDATA), 128'(0));
        chk("rst_be", 128'(MEM_BE), 128'(8'hFF));
        chk("rst_tdo", 128'(TDO), 128'(0));
        RESET = 1'b0;
        tick();
        check_status("rst_status");

        // Prefetch read, zero-wait.
        bus_mem[32'h1000] = 64'hA5; ref_mem[32'h1000] = 64'hA5;
        op_load(32'h1000, 1'b0, 1'b1);
        check_status("read_a5");

        // Auto-increment writes.
        op_load(32'h2000, 1'b1, 1'b1);
        op_update(64'd1);
        op_update(64'd2);
        op_update(64'd3);
        check_status("write_seq");

        // Delayed grant; UPDATE while waiting is dropped and flags ERR.
        gnt_delay = 5;
        scan({2'b00, 64'd4}, dout);
        pulse_update();
        tick(2);
        pulse_update();
        expect_txn(1'b1, m_addr, 64'd4, 1'b1);
        m_err = 1'b1;
        check_status("drop_update");

        // BUSY visible in capture during a long wait.
        gnt_delay = 100;
        addr_load(32'h6000, 1'b0, 1'b0);
        m_addr = 32'h6000; m_wrm = 1'b0; m_inc = 1'b0; m_err = 1'b0;
        scan('0, dout);
        chk("busy_capture", 128'(dout), 128'({1'b1, 1'b0, m_rbuf}));
        expect_txn(1'b0, 32'h6000, '0, 1'b1);
        gnt_delay = 0;

        // Bus errors: sticky ERR, RBUF kept, no increment on failed write.
        err_inj = 1'b1;
        op_load(32'h3000, 1'b0, 1'b1);
        err_inj = 1'b0;
        check_status("read_err");
        op_load(32'h3000, 1'b1, 1'b1);
        err_inj = 1'b1;
        op_update(64'hDEAD);
        err_inj = 1'b0;
        op_update(64'hBEEF);
        check_status("write_err_sticky");
        op_load(32'h3100, 1'b0, 1'b0);
        check_status("err_cleared");

        // Address wrap.
        op_load(32'hFFFF_FFF8, 1'b0, 1'b1);
        op_update('0);
        check_status("addr_wrap");

        // ADDR_LOAD while busy: first read discarded, prefetch follows.
        gnt_delay = 4;
        addr_load(32'h1000, 1'b0, 1'b0);
        tick();
        addr_load(32'h5008, 1'b0, 1'b0);
        m_addr = 32'h5008; m_wrm = 1'b0; m_inc = 1'b0; m_err = 1'b0;
        expect_txn(1'b0, 32'h1000, '0, 1'b0);
        expect_txn(1'b0, 32'h5008, '0, 1'b1);
        check_status("reload_busy");

        // Randomized mix of loads and updates.
        for (int it = 0; it < 40; it++) begin
            gnt_delay = $urandom_range(0, 3);
            err_inj = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                a = 32'h4000 + 32'($urandom_range(0, 31)) * 8;
                op_load(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                op_update({$urandom, $urandom});
            end
            err_inj = 1'b0;
            check_status("rand_status");
        end

        // RESET while a request is outstanding.
        gnt_delay = 50;
        addr_load(32'h7000, 1'b0, 1'b0);
        tick(3);
        RESET = 1'b1;
        tick();
        chk("rst_mid_req", 128'(MEM_REQ), 128'(0));
        chk("rst_mid_addr", 128'(MEM_ADDR), 128'(0));
        RESET = 1'b0;
        tick();
        chk("rst_mid_no_txn", 128'(obs_q.size()), 128'(0));
        m_addr = '0; m_wrm = 1'b0; m_inc = 1'b0; m_err = 1'b0; m_rbuf = '0;
        gnt_delay = 0;
        check_status("rst_mid_status");

`ifdef JTAG_MEM_TIMEOUT_EN
        resp_en = 1'b0;
        addr_load(32'h5000, 1'b0, 1'b0);
        m_addr = 32'h5000; m_wrm = 1'b0; m_inc = 1'b0; m_err = 1'b1;
        n = 0;
        while (MEM_REQ && n < 1200) begin
            tick();
            n++;
        end
        chk("timeout_req_drop", 128'(MEM_REQ), 128'(0));
        chk("timeout_len", 128'(n >= 1018 && n <= 1030), 128'(1));
        resp_en = 1'b1;
        check_status("timeout_status");
`else
        n = 0;
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
